// File: rtl/axilite_tmr_responder.sv
// Triple-modular-redundant AXI4-Lite slave: three lanes vote on each write/read
// against a 4-word register file; dissenting or missing lanes are flagged.
module axilite_tmr_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [3*C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                        s_axi_awvalid,
  output logic [2:0]                        s_axi_awready,
  input  logic [3*C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [3*C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic [2:0]                        s_axi_wvalid,
  output logic [2:0]                        s_axi_wready,
  output logic [5:0]                        s_axi_bresp,
  output logic [2:0]                        s_axi_bvalid,
  input  logic [2:0]                        s_axi_bready,
  input  logic [3*C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                        s_axi_arvalid,
  output logic [2:0]                        s_axi_arready,
  output logic [3*C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [5:0]                        s_axi_rresp,
  output logic [2:0]                        s_axi_rvalid,
  input  logic [2:0]                        s_axi_rready,
  output logic                              vote_err,
  output logic [2:0]                        fault_lane
);

  localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned IW   = AW - 2;
  localparam int unsigned NREG = 1 << IW;
  localparam int unsigned TW   = IW + DW + SW;
  localparam int unsigned CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_VOTE, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_COLLECT, R_VOTE, R_RESP} r_state_t;

  // A lane is in the majority when it matches at least one other captured lane.
  function automatic logic [2:0] agree3(input logic [2:0] c, input logic e01,
                                        input logic e02, input logic e12);
    logic [2:0] a;
    a[0] = c[0] & ((c[1] & e01) | (c[2] & e02));
    a[1] = c[1] & ((c[0] & e01) | (c[2] & e12));
    a[2] = c[2] & ((c[0] & e02) | (c[1] & e12));
    return a;
  endfunction

  function automatic logic two3(input logic [2:0] c);
    return (c[0] & c[1]) | (c[0] & c[2]) | (c[1] & c[2]);
  endfunction

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  logic [DW-1:0] regs [NREG];

  // ---------------- write path ----------------
  w_state_t      w_state, w_state_nxt;
  logic [2:0]    aw_hs, w_hs, aw_done, w_done, aw_done_nxt, w_done_nxt, wcap_nxt;
  logic [TW-1:0] wt_q [3];
  logic [TW-1:0] wt_nxt [3];
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic [2:0]    wcap_q, wagr_q, wagr_c;
  logic [TW-1:0] wmaj_q;
  logic          w_enter;
  logic [2:0]    awready_nxt, wready_nxt, bvalid_nxt;
  logic [5:0]    bresp_nxt;

  // Per-lane capture of the (word index, data, strobe) tuple as handshakes land
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      aw_hs[k]  = s_axi_awvalid[k] & s_axi_awready[k];
      w_hs[k]   = s_axi_wvalid[k] & s_axi_wready[k];
      wt_nxt[k] = wt_q[k];
      if (aw_hs[k]) wt_nxt[k][TW-1 -: IW] = s_axi_awaddr[k*AW+2 +: IW];
      if (w_hs[k])  wt_nxt[k][DW+SW-1:0]  = {s_axi_wdata[k*DW +: DW], s_axi_wstrb[k*SW +: SW]};
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    wcnt_nxt    = wcnt;
    aw_done_nxt = aw_done | aw_hs;
    w_done_nxt  = w_done | w_hs;
    wcap_nxt    = aw_done_nxt & w_done_nxt;
    wagr_c      = agree3(wcap_nxt, wt_nxt[0] == wt_nxt[1], wt_nxt[0] == wt_nxt[2],
                         wt_nxt[1] == wt_nxt[2]);
    w_enter     = 1'b0;
    bvalid_nxt  = s_axi_bvalid & ~s_axi_bready;
    bresp_nxt   = s_axi_bresp;
    case (w_state)
      W_IDLE: begin
        if (&wcap_nxt) begin
          w_state_nxt = W_VOTE;
          w_enter     = 1'b1;
        end else if (|wcap_nxt) begin
          w_state_nxt = W_COLLECT;
          wcnt_nxt    = '0;
        end
      end
      W_COLLECT: begin
        if ((&wcap_nxt) || (wcnt == CNT_LAST && two3(wcap_nxt))) begin
          w_state_nxt = W_VOTE;
          w_enter     = 1'b1;
        end else if (wcnt != CNT_LAST) begin
          wcnt_nxt = wcnt + CW'(1);
        end
      end
      W_VOTE: begin
        w_state_nxt = W_RESP;
        bvalid_nxt  = wcap_q;
        for (int k = 0; k < 3; k++)
          bresp_nxt[2*k +: 2] = (wcap_q[k] & ~wagr_q[k]) ? 2'b10 : 2'b00;
        // Partially accepted lanes keep their flags for the next round
        aw_done_nxt = aw_done & ~wcap_q;
        w_done_nxt  = w_done & ~wcap_q;
      end
      W_RESP: begin
        if ((s_axi_bvalid & ~s_axi_bready) == 3'b000) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
    awready_nxt = (w_state_nxt == W_IDLE || w_state_nxt == W_COLLECT) ? ~aw_done_nxt : 3'b000;
    wready_nxt  = (w_state_nxt == W_IDLE || w_state_nxt == W_COLLECT) ? ~w_done_nxt  : 3'b000;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      aw_done       <= '0;
      w_done        <= '0;
      wcnt          <= '0;
      wcap_q        <= '0;
      wagr_q        <= '0;
      wmaj_q        <= '0;
      s_axi_awready <= '0;
      s_axi_wready  <= '0;
      s_axi_bvalid  <= '0;
      s_axi_bresp   <= '0;
      for (int k = 0; k < 3; k++) wt_q[k] <= '0;
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else begin
      w_state       <= w_state_nxt;
      aw_done       <= aw_done_nxt;
      w_done        <= w_done_nxt;
      wcnt          <= wcnt_nxt;
      s_axi_awready <= awready_nxt;
      s_axi_wready  <= wready_nxt;
      s_axi_bvalid  <= bvalid_nxt;
      s_axi_bresp   <= bresp_nxt;
      for (int k = 0; k < 3; k++) wt_q[k] <= wt_nxt[k];
      if (w_enter) begin
        wcap_q <= wcap_nxt;
        wagr_q <= wagr_c;
        wmaj_q <= wagr_c[0] ? wt_nxt[0] : wt_nxt[1];
      end
      if (w_state == W_VOTE && (|wagr_q)) begin
        for (int b = 0; b < int'(SW); b++)
          if (wmaj_q[b]) regs[wmaj_q[TW-1 -: IW]][8*b +: 8] <= wmaj_q[SW+8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t      r_state, r_state_nxt;
  logic [2:0]    ar_hs, ar_done, ar_done_nxt;
  logic [IW-1:0] rt_q [3];
  logic [IW-1:0] rt_nxt [3];
  logic [CW-1:0] rcnt, rcnt_nxt;
  logic [2:0]    rcap_q, ragr_q, ragr_c;
  logic [IW-1:0] rmaj_q;
  logic          r_enter;
  logic [2:0]    arready_nxt, rvalid_nxt;
  logic [5:0]    rresp_nxt;
  logic [3*DW-1:0] rdata_nxt;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ar_hs[k]  = s_axi_arvalid[k] & s_axi_arready[k];
      rt_nxt[k] = ar_hs[k] ? s_axi_araddr[k*AW+2 +: IW] : rt_q[k];
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    rcnt_nxt    = rcnt;
    ar_done_nxt = ar_done | ar_hs;
    ragr_c      = agree3(ar_done_nxt, rt_nxt[0] == rt_nxt[1], rt_nxt[0] == rt_nxt[2],
                         rt_nxt[1] == rt_nxt[2]);
    r_enter     = 1'b0;
    rvalid_nxt  = s_axi_rvalid & ~s_axi_rready;
    rresp_nxt   = s_axi_rresp;
    rdata_nxt   = s_axi_rdata;
    case (r_state)
      R_IDLE: begin
        if (&ar_done_nxt) begin
          r_state_nxt = R_VOTE;
          r_enter     = 1'b1;
        end else if (|ar_done_nxt) begin
          r_state_nxt = R_COLLECT;
          rcnt_nxt    = '0;
        end
      end
      R_COLLECT: begin
        if ((&ar_done_nxt) || (rcnt == CNT_LAST && two3(ar_done_nxt))) begin
          r_state_nxt = R_VOTE;
          r_enter     = 1'b1;
        end else if (rcnt != CNT_LAST) begin
          rcnt_nxt = rcnt + CW'(1);
        end
      end
      R_VOTE: begin
        // Register file is sampled before any same-cycle write commits
        r_state_nxt = R_RESP;
        rvalid_nxt  = rcap_q;
        for (int k = 0; k < 3; k++) begin
          rresp_nxt[2*k +: 2]  = (rcap_q[k] & ~ragr_q[k]) ? 2'b10 : 2'b00;
          rdata_nxt[k*DW +: DW] = (rcap_q[k] && (|ragr_q)) ? regs[rmaj_q] : '0;
        end
        ar_done_nxt = ar_done & ~rcap_q;
      end
      R_RESP: begin
        if ((s_axi_rvalid & ~s_axi_rready) == 3'b000) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
    arready_nxt = (r_state_nxt == R_IDLE || r_state_nxt == R_COLLECT) ? ~ar_done_nxt : 3'b000;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      ar_done       <= '0;
      rcnt          <= '0;
      rcap_q        <= '0;
      ragr_q        <= '0;
      rmaj_q        <= '0;
      s_axi_arready <= '0;
      s_axi_rvalid  <= '0;
      s_axi_rresp   <= '0;
      s_axi_rdata   <= '0;
      for (int k = 0; k < 3; k++) rt_q[k] <= '0;
    end else begin
      r_state       <= r_state_nxt;
      ar_done       <= ar_done_nxt;
      rcnt          <= rcnt_nxt;
      s_axi_arready <= arready_nxt;
      s_axi_rvalid  <= rvalid_nxt;
      s_axi_rresp   <= rresp_nxt;
      s_axi_rdata   <= rdata_nxt;
      for (int k = 0; k < 3; k++) rt_q[k] <= rt_nxt[k];
      if (r_enter) begin
        rcap_q <= ar_done_nxt;
        ragr_q <= ragr_c;
        rmaj_q <= ragr_c[0] ? rt_nxt[0] : rt_nxt[1];
      end
    end
  end

  // Error pulse and sticky fault flags land in the vote cycle of either path
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      vote_err   <= 1'b0;
      fault_lane <= '0;
    end else begin
      vote_err   <= (w_enter && wagr_c != 3'b111) || (r_enter && ragr_c != 3'b111);
      fault_lane <= fault_lane | (w_enter ? ~wagr_c : 3'b000) | (r_enter ? ~ragr_c : 3'b000);
    end
  end

endmodule

// File: tb/tb_axilite_tmr_responder.sv
// Directed bench for the TMR AXI-Lite responder: voting, timeout, strobes, collisions, reset.
module tb_axilite_tmr_responder;

  localparam int T = 8;

  logic        ACLK, ARESETN;
  logic [11:0] s_axi_awaddr, s_axi_araddr;
  logic [2:0]  s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [95:0] s_axi_wdata, s_axi_rdata;
  logic [11:0] s_axi_wstrb;
  logic [5:0]  s_axi_bresp, s_axi_rresp;
  logic [2:0]  s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [2:0]  s_axi_rvalid, s_axi_rready, fault_lane;
  logic        vote_err;

  int tests = 0;
  int fails = 0;

  axilite_tmr_responder #(.TIMEOUT_CYCLES(T)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .vote_err(vote_err),
    .fault_lane(fault_lane)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Raise valids on the masked lanes at a negedge, drop each after its handshake edge.
  // Returns at the negedge following the last handshake.
  task automatic xfer(input logic [2:0] wm, input logic [2:0] rm, input logic [11:0] aa,
                      input logic [95:0] wd, input logic [3:0] st, input logic [11:0] ra);
    logic [2:0] awp, wp, arp;
    int n;
    awp = wm; wp = wm; arp = rm; n = 0;
    s_axi_awaddr = aa; s_axi_wdata = wd; s_axi_wstrb = {3{st}}; s_axi_araddr = ra;
    s_axi_awvalid = awp; s_axi_wvalid = wp; s_axi_arvalid = arp;
    while ((awp | wp | arp) != 3'b000 && n < 50) begin
      awp = awp & ~s_axi_awready;
      wp  = wp & ~s_axi_wready;
      arp = arp & ~s_axi_arready;
      @(negedge ACLK);
      s_axi_awvalid = awp; s_axi_wvalid = wp; s_axi_arvalid = arp;
      n++;
    end
    chk("xfer_accept", {93'b0, awp | wp | arp}, 96'b0);
  endtask

  task automatic wr(input string tag, input logic [11:0] aa, input logic [95:0] wd,
                    input logic [3:0] st, input logic exp_err, input logic [5:0] exp_bresp,
                    input logic [2:0] exp_fault);
    xfer(3'b111, 3'b000, aa, wd, st, 12'h0);
    chk({tag, "_err"}, 96'(vote_err), 96'(exp_err));
    chk({tag, "_fault"}, 96'(fault_lane), 96'(exp_fault));
    chk({tag, "_bvalid_early"}, 96'(s_axi_bvalid), 96'h0);
    @(negedge ACLK);
    chk({tag, "_bvalid"}, 96'(s_axi_bvalid), 96'h7);
    chk({tag, "_bresp"}, 96'(s_axi_bresp), 96'(exp_bresp));
    @(negedge ACLK);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    xfer(3'b000, 3'b111, 12'h0, 96'h0, 4'h0, {3{a}});
    @(negedge ACLK);
    chk({tag, "_rvalid"}, 96'(s_axi_rvalid), 96'h7);
    chk({tag, "_rdata"}, s_axi_rdata, {3{exp}});
    chk({tag, "_rresp"}, 96'(s_axi_rresp), 96'h0);
    @(negedge ACLK);
  endtask

  initial begin
    int n;
    logic seen;
    ARESETN = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = '0; s_axi_bready = 3'b111; s_axi_araddr = '0; s_axi_arvalid = '0;
    s_axi_rready = 3'b111;
    repeat (2) @(negedge ACLK);
    chk("rst_awready", 96'(s_axi_awready), 96'h0);
    chk("rst_arready", 96'(s_axi_arready), 96'h0);
    chk("rst_bvalid", 96'(s_axi_bvalid), 96'h0);
    chk("rst_rvalid", 96'(s_axi_rvalid), 96'h0);
    chk("rst_rdata", s_axi_rdata, 96'h0);
    chk("rst_vote_err", 96'(vote_err), 96'h0);
    chk("rst_fault", 96'(fault_lane), 96'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("idle_awready", 96'(s_axi_awready), 96'h7);
    chk("idle_wready", 96'(s_axi_wready), 96'h7);
    chk("idle_arready", 96'(s_axi_arready), 96'h7);

    // Unanimous write and read-back
    wr("w_all", {3{4'h0}}, {3{32'h0000_0001}}, 4'hF, 1'b0, 6'b00_00_00, 3'b000);
    rd("r_all", 4'h0, 32'h0000_0001);

    // Byte strobe: only byte 1 of reg0 changes
    wr("w_strb", {3{4'h0}}, {3{32'hAABB_CCDD}}, 4'b0010, 1'b0, 6'b00_00_00, 3'b000);
    rd("r_strb", 4'h0, 32'h0000_CC01);

    // Lane 2 dissents on data
    wr("w_dis", {3{4'h4}}, {32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hA5A5_A5A5}, 4'hF,
       1'b1, 6'b10_00_00, 3'b100);
    rd("r_dis", 4'h4, 32'hA5A5_A5A5);

    // Lane 2 silent: vote after the timeout with two lanes
    xfer(3'b011, 3'b000, {3{4'h8}}, {3{32'h0000_0002}}, 4'hF, 12'h0);
    n = 0; seen = 1'b0;
    while (s_axi_bvalid == 3'b000 && n < 40) begin
      seen = seen | vote_err;
      @(negedge ACLK);
      n++;
    end
    chk("to_latency", 96'(n), 96'(T + 1));
    chk("to_bvalid", 96'(s_axi_bvalid), 96'h3);
    chk("to_bresp", 96'(s_axi_bresp), 96'h0);
    chk("to_err", 96'(seen), 96'h1);
    chk("to_fault", 96'(fault_lane), 96'h4);
    @(negedge ACLK);
    rd("r_to", 4'h8, 32'h0000_0002);

    // Late lane 2 opens a new round that lanes 0 and 1 then complete
    xfer(3'b100, 3'b000, {3{4'h8}}, {3{32'h0000_0005}}, 4'hF, 12'h0);
    chk("late_awready", 96'(s_axi_awready), 96'h3);
    xfer(3'b011, 3'b000, {3{4'h8}}, {3{32'h0000_0005}}, 4'hF, 12'h0);
    chk("late_err", 96'(vote_err), 96'h0);
    @(negedge ACLK);
    chk("late_bvalid", 96'(s_axi_bvalid), 96'h7);
    chk("late_bresp", 96'(s_axi_bresp), 96'h0);
    @(negedge ACLK);
    rd("r_late", 4'h8, 32'h0000_0005);

    // Three distinct addresses: no majority
    wr("w_nomaj", {4'h8, 4'h4, 4'h0}, {3{32'hFFFF_FFFF}}, 4'hF, 1'b1, 6'b10_10_10, 3'b111);
    rd("r_nomaj0", 4'h0, 32'h0000_CC01);
    rd("r_nomaj1", 4'h4, 32'hA5A5_A5A5);
    rd("r_nomaj2", 4'h8, 32'h0000_0005);

    // Same-cycle write and read of reg3 with lane 1 stalling its bready
    wr("w_r3", {3{4'hC}}, {3{32'h1111_1111}}, 4'hF, 1'b0, 6'b00_00_00, 3'b111);
    s_axi_bready = 3'b101;
    xfer(3'b111, 3'b111, {3{4'hC}}, {3{32'h2222_2222}}, 4'hF, {3{4'hC}});
    chk("col_err", 96'(vote_err), 96'h0);
    @(negedge ACLK);
    chk("col_bvalid", 96'(s_axi_bvalid), 96'h7);
    chk("col_rvalid", 96'(s_axi_rvalid), 96'h7);
    chk("col_rdata", s_axi_rdata, {3{32'h1111_1111}});
    @(negedge ACLK);
    chk("stall_bvalid", 96'(s_axi_bvalid), 96'h2);
    chk("stall_rvalid", 96'(s_axi_rvalid), 96'h0);
    repeat (3) @(negedge ACLK);
    chk("stall_bvalid_held", 96'(s_axi_bvalid), 96'h2);
    chk("stall_awready", 96'(s_axi_awready), 96'h0);
    s_axi_bready = 3'b111;
    @(negedge ACLK);
    chk("unstall_bvalid", 96'(s_axi_bvalid), 96'h0);
    chk("unstall_awready", 96'(s_axi_awready), 96'h7);
    rd("r_col", 4'hC, 32'h2222_2222);

    // Reset after lane 0 alone has captured a write
    xfer(3'b001, 3'b000, {3{4'hC}}, {3{32'h0000_0099}}, 4'hF, 12'h0);
    chk("pre_rst_awready", 96'(s_axi_awready), 96'h6);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    chk("mid_rst_bvalid", 96'(s_axi_bvalid), 96'h0);
    chk("mid_rst_fault", 96'(fault_lane), 96'h0);
    chk("mid_rst_awready", 96'(s_axi_awready), 96'h0);
    repeat (3) @(negedge ACLK);
    chk("post_rst_bvalid", 96'(s_axi_bvalid), 96'h0);
    rd("r_rst3", 4'hC, 32'h0);
    rd("r_rst0", 4'h0, 32'h0);
    wr("w_after", {3{4'hC}}, {3{32'h0000_0077}}, 4'hF, 1'b0, 6'b00_00_00, 3'b000);
    rd("r_after", 4'hC, 32'h0000_0077);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
